// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RISC5 CPU, the display-refresh DMA master and the SRAM pins.
// The arbiter connects through the slave modport; the environment uses master.
interface ram_arbiter_if;
    logic [23:0] cpu_adr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_ben;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_wait;

    // DMA handshake: dma_req is held until dma_done; each dma_ack pulse marks
    // one valid dma_rdata word, and dma_done pulses together with the last ack.
    logic        dma_req;
    logic        dma_urgent;
    logic [23:0] dma_adr;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_done;

    logic [21:0] mem_adr;
    logic        mem_ce_n;
    logic        mem_we_n;
    logic [3:0]  mem_be_n;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
        output dma_req, dma_urgent, dma_adr, mem_rdata,
        input  cpu_rdata, cpu_wait, dma_ack, dma_rdata, dma_done,
        input  mem_adr, mem_ce_n, mem_we_n, mem_be_n, mem_wdata
    );

    modport slave (
        input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
        input  dma_req, dma_urgent, dma_adr, mem_rdata,
        output cpu_rdata, cpu_wait, dma_ack, dma_rdata, dma_done,
        output mem_adr, mem_ce_n, mem_we_n, mem_be_n, mem_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one 32-bit SRAM between the RISC5 CPU and a read-only burst DMA master.
// Define ARB_STATS_EN to add the stall/burst statistics counters and their ports.
module ram_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int BURST       = 8,
    parameter int CPU_SLICE   = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus,
    output logic         dbg_state
`ifdef ARB_STATS_EN
    ,
    input  logic         stat_clr,
    output logic [31:0]  stat_cpu_stall,
    output logic [15:0]  stat_bursts
`endif
);
    typedef enum logic {CPU_ACC = 1'b0, DMA_ACC = 1'b1} state_e;

    localparam logic [2:0] CYC_LAST  = 3'(WAIT_STATES);
    localparam logic [5:0] WORD_LAST = 6'(BURST - 1);
    localparam logic [3:0] SLICE_MIN = 4'(CPU_SLICE);

    state_e      state_q, state_d;
    logic [2:0]  cyc_q, cyc_d;
    logic [3:0]  slice_q, slice_d;
    logic [5:0]  word_q, word_d;
    logic [21:0] ptr_q, ptr_d;
    logic        dma_ack_q, dma_ack_d;
    logic        dma_done_q, dma_done_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        boundary;
    logic        burst_end;
    logic [3:0]  slice_inc;
    logic        unused_bits;

    assign boundary    = (cyc_q == CYC_LAST);
    assign unused_bits = ^{bus.cpu_rd, bus.dma_adr[1:0]};
    assign dbg_state   = (state_q == DMA_ACC);

    // The grant decision counts the CPU access that completes at this boundary.
    always_comb begin
        state_d     = state_q;
        cyc_d       = boundary ? 3'd0 : cyc_q + 3'd1;
        slice_d     = slice_q;
        word_d      = word_q;
        ptr_d       = ptr_q;
        dma_ack_d   = 1'b0;
        dma_done_d  = 1'b0;
        dma_rdata_d = dma_rdata_q;
        burst_end   = 1'b0;
        slice_inc   = (slice_q == 4'hF) ? slice_q : slice_q + 4'd1;
        if (boundary) begin
            case (state_q)
                CPU_ACC: begin
                    if (bus.dma_req && (bus.dma_urgent || slice_inc >= SLICE_MIN)) begin
                        state_d = DMA_ACC;
                        slice_d = 4'd0;
                        word_d  = 6'd0;
                        ptr_d   = bus.dma_adr[23:2];
                    end else begin
                        slice_d = slice_inc;
                    end
                end
                DMA_ACC: begin
                    dma_rdata_d = bus.mem_rdata;
                    dma_ack_d   = 1'b1;
                    ptr_d       = ptr_q + 22'd1;
                    burst_end   = (word_q == WORD_LAST);
                    if (burst_end) begin
                        dma_done_d = 1'b1;
                        state_d    = CPU_ACC;
                        word_d     = 6'd0;
                    end else begin
                        word_d = word_q + 6'd1;
                    end
                end
                default: state_d = CPU_ACC;
            endcase
        end
    end

    // Pin outputs are gated by rst directly so they go idle the moment reset asserts.
    always_comb begin
        bus.mem_adr   = bus.cpu_adr[23:2];
        bus.mem_ce_n  = 1'b1;
        bus.mem_we_n  = 1'b1;
        bus.mem_be_n  = 4'hF;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_wait  = 1'b1;
        bus.cpu_rdata = 32'd0;
        if (rst) begin
            bus.mem_ce_n = 1'b0;
            if (state_q == CPU_ACC) begin
                bus.mem_we_n = ~bus.cpu_wr;
                bus.mem_be_n = (bus.cpu_wr && bus.cpu_ben) ? ~(4'b0001 << bus.cpu_adr[1:0]) : 4'b0000;
                if (boundary) begin
                    bus.cpu_wait  = 1'b0;
                    bus.cpu_rdata = bus.mem_rdata;
                end
            end else begin
                bus.mem_adr  = ptr_q;
                bus.mem_be_n = 4'b0000;
            end
        end
    end

    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_rdata = dma_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CPU_ACC;
            cyc_q       <= 3'd0;
            slice_q     <= 4'd0;
            word_q      <= 6'd0;
            ptr_q       <= 22'd0;
            dma_ack_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            slice_q     <= slice_d;
            word_q      <= word_d;
            ptr_q       <= ptr_d;
            dma_ack_q   <= dma_ack_d;
            dma_done_q  <= dma_done_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] bursts_q, bursts_d;

    // cpu_wait is always high in DMA_ACC, so every DMA cycle is a CPU stall cycle.
    always_comb begin
        stall_d  = stall_q;
        bursts_d = bursts_q;
        if (stat_clr) begin
            stall_d  = 32'd0;
            bursts_d = 16'd0;
        end else begin
            if (state_q == DMA_ACC) stall_d = stall_q + 32'd1;
            if (burst_end) bursts_d = bursts_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= 32'd0;
            bursts_q <= 16'd0;
        end else begin
            stall_q  <= stall_d;
            bursts_q <= bursts_d;
        end
    end

    assign stat_cpu_stall = stall_q;
    assign stat_bursts    = bursts_q;
`endif
endmodule
